// File: rtl/psram_ddr_rx.sv
// PSRAM DDR read-data capture: qualifies byte pairs by RWDS, packs 16-bit words into a FWFT FIFO.
// Optional strobe timeout is compiled in with `define PSRAM_RX_TIMEOUT_EN.
module psram_ddr_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             rd_start,
    input  logic [LEN_W-1:0] rd_len,
    input  logic [7:0]       ddr_q0,
    input  logic [7:0]       ddr_q1,
    input  logic [1:0]       ddr_strb,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_busy,
    output logic             rd_done,
    output logic             rd_err,
    output logic             rd_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] ONE_WORD = LEN_W'(1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
        $error("psram_ddr_rx: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV, S_DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [LEN_W-1:0] remain;
    logic             zero_done;
    logic             ovf_q;

    logic strb_vld;
    logic capturing;
    logic take;
    logic last_word;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic start_ok;
    logic timeout;

    assign strb_vld  = (ddr_strb == 2'b10);
    assign capturing = (state == S_WAIT) || (state == S_RECV);
    assign take      = capturing && strb_vld;
    assign last_word = take && (remain == ONE_WORD);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = rd_valid && rd_ready;
    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign push      = take && (!fifo_full || pop);
    assign drop      = take && fifo_full && !pop;
    assign start_ok  = (state == S_IDLE) && rd_start;

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rptr] : 16'h0000;
    assign rd_busy  = (state != S_IDLE);
    assign rd_ovf   = ovf_q;

`ifdef PSRAM_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign timeout = capturing && !strb_vld && (to_cnt == TO_LAST);
    assign rd_err  = err_q;

    // Cleared outside WAIT/RECV, so every entry into WAIT or RECV starts from zero.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!capturing || strb_vld) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (start_ok) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign rd_err  = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_done   = zero_done;
        case (state)
            S_IDLE: begin
                if (rd_start && (rd_len != '0)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT, S_RECV: begin
                if (last_word || timeout) begin
                    state_nxt = S_DRAIN;
                end else if (take) begin
                    state_nxt = S_RECV;
                end
            end
            S_DRAIN: begin
                if (count == '0) begin
                    rd_done   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            remain    <= '0;
            zero_done <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            zero_done <= start_ok && (rd_len == '0);
            if (start_ok) begin
                remain <= rd_len;
                ovf_q  <= 1'b0;
            end else begin
                if (take) begin
                    remain <= remain - 1'b1;
                end
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // FIFO control; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; rd_data is masked while the FIFO is empty.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wptr] <= {ddr_q0, ddr_q1};
        end
    end

endmodule

// File: tb/tb_psram_ddr_rx.sv
// Directed bench for psram_ddr_rx: burst capture, idle strobes, overflow, timeout/stall, zero length, reset.
module tb_psram_ddr_rx;

    logic        sys_clk;
    logic        sys_rst;
    logic        rd_start;
    logic [9:0]  rd_len;
    logic [7:0]  ddr_q0;
    logic [7:0]  ddr_q1;
    logic [1:0]  ddr_strb;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_err;
    logic        rd_ovf;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_basic [4] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607};

    psram_ddr_rx #(
        .FIFO_DEPTH(4),
        .LEN_W     (10),
        .TIMEOUT   (64)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rd_start(rd_start),
        .rd_len  (rd_len),
        .ddr_q0  (ddr_q0),
        .ddr_q1  (ddr_q1),
        .ddr_strb(ddr_strb),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_busy (rd_busy),
        .rd_done (rd_done),
        .rd_err  (rd_err),
        .rd_ovf  (rd_ovf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start(input logic [9:0] len);
        rd_start = 1'b1;
        rd_len   = len;
        tick();
        rd_start = 1'b0;
        rd_len   = '0;
    endtask

    task automatic drive(input logic [1:0] strb, input logic [15:0] w);
        ddr_strb = strb;
        ddr_q0   = w[15:8];
        ddr_q1   = w[7:0];
    endtask

    // Four back-to-back words with the consumer always ready.
    task automatic run_basic(input string tag);
        rd_ready = 1'b1;
        start(10'd4);
        chk({tag, "_busy_rise"}, rd_busy, 1);
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, exp_basic[i]);
            tick();
            chk({tag, "_valid"}, rd_valid, 1);
            chk({tag, "_data"}, rd_data, exp_basic[i]);
        end
        drive(2'b00, 16'h0000);
        chk({tag, "_done_early"}, rd_done, 0);
        tick();
        chk({tag, "_done"}, rd_done, 1);
        chk({tag, "_err"}, rd_err, 0);
        chk({tag, "_ovf"}, rd_ovf, 0);
        tick();
        chk({tag, "_busy_fall"}, rd_busy, 0);
        chk({tag, "_done_pulse"}, rd_done, 0);
    endtask

    logic [1:0]  s2_strb [12] = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10,
                                  2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [15:0] s2_word [12] = '{16'hEEFF, 16'hEEFF, 16'hEEFF, 16'hEEFF, 16'hEEFF, 16'h1122,
                                  16'hEEFF, 16'h3344, 16'hEEFF, 16'hEEFF, 16'h5566, 16'hEEFF};
    logic [15:0] s2_exp  [3]  = '{16'h1122, 16'h3344, 16'h5566};
    logic [15:0] s3_exp  [4]  = '{16'hA0B0, 16'hA1B1, 16'hA2B2, 16'hA3B3};

    initial begin
        logic [15:0] got [4];
        int          n_got;
        int          n_done;
        int          done_at;

        sys_rst  = 1'b0;
        rd_start = 1'b0;
        rd_len   = '0;
        ddr_q0   = '0;
        ddr_q1   = '0;
        ddr_strb = 2'b00;
        rd_ready = 1'b0;
        tick();
        tick();
        chk("rst_data", rd_data, 16'h0000);
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", rd_busy, 0);
        chk("rst_done", rd_done, 0);
        chk("rst_err", rd_err, 0);
        chk("rst_ovf", rd_ovf, 0);
        sys_rst = 1'b1;
        tick();

        run_basic("s1");

        // Idle strobe patterns must never produce words.
        rd_ready = 1'b1;
        start(10'd3);
        n_got  = 0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 12) drive(s2_strb[c], s2_word[c]);
            else        drive(2'b00, 16'h0000);
            tick();
            if (rd_valid && rd_ready) begin
                if (n_got < 4) got[n_got] = rd_data;
                n_got++;
            end
            if (rd_done) n_done++;
        end
        chk("s2_word_count", n_got, 3);
        for (int i = 0; i < 3; i++) chk("s2_word", got[i], s2_exp[i]);
        chk("s2_done_count", n_done, 1);
        chk("s2_busy_end", rd_busy, 0);

        // Six words into a four-deep FIFO with no consumer.
        rd_ready = 1'b0;
        start(10'd6);
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, {8'hA0 + 8'(i), 8'hB0 + 8'(i)});
            tick();
            if (i == 3) chk("s3_ovf_not_yet", rd_ovf, 0);
            if (i == 4) chk("s3_ovf_set", rd_ovf, 1);
        end
        drive(2'b00, 16'h0000);
        tick();
        chk("s3_ovf_sticky", rd_ovf, 1);
        chk("s3_busy_drain", rd_busy, 1);
        chk("s3_done_hold", rd_done, 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("s3_valid", rd_valid, 1);
            chk("s3_data", rd_data, s3_exp[i]);
            tick();
        end
        chk("s3_empty", rd_valid, 0);
        chk("s3_done", rd_done, 1);
        chk("s3_ovf_after", rd_ovf, 1);
        tick();
        chk("s3_busy_fall", rd_busy, 0);

        // One word of a two-word burst, then the strobe goes silent.
        start(10'd2);
        chk("s4_ovf_cleared", rd_ovf, 0);
        drive(2'b10, 16'hD0D1);
        tick();
        drive(2'b00, 16'h0000);
        chk("s4_data", rd_data, 16'hD0D1);
`ifdef PSRAM_RX_TIMEOUT_EN
        done_at = 0;
        for (int k = 1; k <= 100; k++) begin
            if (rd_done) begin
                done_at = k;
                break;
            end
            tick();
        end
        chk("s4_timeout_latency", done_at, 65);
        chk("s4_err", rd_err, 1);
        tick();
        chk("s4_err_held", rd_err, 1);
        chk("s4_busy_fall", rd_busy, 0);
`else
        done_at = 0;
        for (int k = 1; k <= 100; k++) begin
            if (rd_done) done_at = k;
            tick();
        end
        chk("s4_no_done", done_at, 0);
        chk("s4_stall_busy", rd_busy, 1);
        chk("s4_stall_err", rd_err, 0);
        #2 sys_rst = 1'b0;
        #1;
        chk("s4_rst_busy", rd_busy, 0);
        tick();
        sys_rst = 1'b1;
        tick();
`endif

        // Zero-length request.
        start(10'd0);
        chk("s5_zero_done", rd_done, 1);
        chk("s5_zero_busy", rd_busy, 0);
        chk("s5_zero_err", rd_err, 0);
        tick();
        chk("s5_zero_done_pulse", rd_done, 0);
        chk("s5_zero_busy_after", rd_busy, 0);

        // rd_start mid-burst is ignored.
        rd_ready = 1'b1;
        start(10'd2);
        drive(2'b10, 16'hC0C1);
        tick();
        chk("s5_mid_w0", rd_data, 16'hC0C1);
        drive(2'b00, 16'h0000);
        rd_start = 1'b1;
        rd_len   = 10'd5;
        tick();
        rd_start = 1'b0;
        rd_len   = '0;
        chk("s5_mid_busy", rd_busy, 1);
        drive(2'b10, 16'hC2C3);
        tick();
        chk("s5_mid_w1", rd_data, 16'hC2C3);
        drive(2'b00, 16'h0000);
        tick();
        chk("s5_mid_done", rd_done, 1);
        tick();
        chk("s5_mid_idle", rd_busy, 0);

        // Asynchronous reset with two words buffered.
        rd_ready = 1'b0;
        start(10'd4);
        drive(2'b10, 16'h1357);
        tick();
        drive(2'b10, 16'h2468);
        tick();
        drive(2'b00, 16'h0000);
        chk("s6_pre_valid", rd_valid, 1);
        chk("s6_pre_data", rd_data, 16'h1357);
        #2 sys_rst = 1'b0;
        #1;
        chk("s6_rst_valid", rd_valid, 0);
        chk("s6_rst_busy", rd_busy, 0);
        chk("s6_rst_data", rd_data, 16'h0000);
        tick();
        sys_rst = 1'b1;
        tick();
        chk("s6_post_valid", rd_valid, 0);
        chk("s6_post_done", rd_done, 0);
        run_basic("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
